// File: rtl/i2c_target_regs.sv
// I2C target responder with a byte-wide register file and a host-side access port.
// SCL/SDA are oversampled on system_clock; SDA is only ever pulled low.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h50,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYC    = 4
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    input  logic                     host_we,
    input  logic [7:0]               host_wdata,
    output logic [7:0]               host_rdata,
    output logic                     wr_pulse,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PTR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } state_t;

    state_t        state;
    logic [2:0]    scl_q;
    logic [2:0]    sda_q;
    logic          scl_s;
    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic [3:0]    bit_cnt;
    logic [6:0]    rx_sh;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_sh;
    logic          ack_pend;
    logic          rw;
    logic [AW-1:0] ptr;
    logic [7:0]    wr_byte;
    logic          hold_act;
    logic [HW-1:0] hold_cnt;
    logic [7:0]    regs [DEPTH];

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign scl_s     = scl_q[1];
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = ~sda_q[1] & sda_q[2] & scl_s & scl_q[2];
    assign stop_det  = sda_q[1] & ~sda_q[2] & scl_s & scl_q[2];
    assign rx_byte   = {rx_sh, sda_s};

    assign host_rdata = regs[host_addr];

    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_sh    <= '0;
            rd_sh    <= '0;
            ack_pend <= 1'b0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            ptr      <= '0;
            wr_pulse <= 1'b0;
            wr_byte  <= '0;
            hold_act <= 1'b0;
            hold_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse <= 1'b0;
            // The bus write lands after the host write so it wins a same-register collision
            if (host_we) begin
                regs[host_addr] <= host_wdata;
            end
            if (wr_pulse) begin
                regs[ptr] <= wr_byte;
                ptr       <= ptr + AW'(1);
            end

            if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                hold_act <= 1'b0;
                ack_pend <= 1'b0;
            end else if (stop_det) begin
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                hold_act <= 1'b0;
                ack_pend <= 1'b0;
            end else begin
                // Every SDA change is deferred HOLD_CYC cycles past the detected SCL fall
                if (scl_fall) begin
                    hold_act <= 1'b1;
                    hold_cnt <= HW'(HOLD_CYC - 1);
                end else if (hold_act) begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end else begin
                        hold_act <= 1'b0;
                        sda_oe   <= 1'b0;
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= ack_pend;
                        end else if (state == ST_RD_DATA) begin
                            if (bit_cnt == 4'd0) begin
                                rd_sh  <= {regs[ptr][6:0], 1'b0};
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                rd_sh  <= {rd_sh[6:0], 1'b0};
                                sda_oe <= ~rd_sh[7];
                            end
                        end
                    end
                end

                if (scl_rise && state != ST_IDLE && state != ST_IGNORE) begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt  <= '0;
                        ack_pend <= 1'b0;
                        case (state)
                            ST_ADDR:    state <= rw ? ST_RD_DATA : ST_PTR;
                            ST_PTR:     state <= ST_WR_DATA;
                            ST_RD_DATA: begin
                                ptr <= ptr + AW'(1);
                                if (sda_s) begin
                                    state <= ST_IGNORE;
                                end
                            end
                            default:    ;
                        endcase
                    end else begin
                        rx_sh   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            case (state)
                                ST_ADDR: begin
                                    if (rx_sh == TARGET_ADDR) begin
                                        ack_pend <= 1'b1;
                                        busy     <= 1'b1;
                                        rw       <= sda_s;
                                    end else begin
                                        state <= ST_IGNORE;
                                        busy  <= 1'b0;
                                    end
                                end
                                ST_PTR: begin
                                    ptr      <= rx_byte[AW-1:0];
                                    ack_pend <= 1'b1;
                                end
                                ST_WR_DATA: begin
                                    wr_byte  <= rx_byte;
                                    wr_pulse <= 1'b1;
                                    ack_pend <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- Synthesizable I2C target (slave) responder with a byte-wide register file; it is the bus-side counterpart to the UVC controller and the interface protocol checkers.
- Oversamples SCL/SDA on `system_clock`, decodes START/STOP/address/data, ACKs its address, and executes pointer-based register writes and reads.
- Open-drain style: drives SDA low only; SCL is never driven (no clock stretching).
- A host-side port gives on-chip logic access to the same registers.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit I2C address answered.
- DEPTH, 16, number of 8-bit registers; power of 2, 2..256.
- HOLD_CYC, 4, `system_clock` cycles after detected SCL fall before SDA output changes (data hold).

Ports:
- system_clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- scl_i  in  1  bus SCL (resolved wire value).
- sda_i  in  1  bus SDA (resolved wire value).
- sda_oe  out  1  1 = pull SDA low; 0 = release (high-Z).
- host_addr  in  $clog2(DEPTH)  host register index.
- host_we  in  1  host write strobe.
- host_wdata  in  8  host write data.
- host_rdata  out  8  combinational read of reg[host_addr].
- wr_pulse  out  1  one-cycle pulse per I2C register write.
- busy  out  1  high from addressed START until STOP/mismatch.

Behaviour:
- Reset (async): sda_oe=0, busy=0, wr_pulse=0, state=IDLE, ptr=0, all registers=8'h00, sync flops=1.
- Input sync: 2-FF synchronizers on scl_i/sda_i, then a third flop for edge detect. Event latency is 3 cycles from pin change.
- START = synced SDA falls while synced SCL high. STOP = synced SDA rises while synced SCL high.
- START in any state (including repeated START): go to ADDR, bit counter=0, sda_oe=0.
- STOP in any state: go to IDLE, sda_oe=0, busy=0.
- Data bits are sampled on synced SCL rising edge, MSB first. Bit counter runs 0..8; bit 8 is the ACK slot.
- All sda_oe changes occur exactly HOLD_CYC cycles after detected SCL fall, never while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If [7:1]==TARGET_ADDR, drive ACK (sda_oe=1 for the 9th clock) and set busy=1. Then go to PTR if R/W=0, or RD_DATA if R/W=1. On mismatch go to IGNORE (no ACK).
  - PTR: receive 8 bits; ptr = byte mod DEPTH; ACK; go to WR_DATA.
  - WR_DATA: receive byte; write reg[ptr] on the 8th sampling edge +1 cycle; pulse wr_pulse; ACK; ptr = (ptr+1) mod DEPTH; stay in WR_DATA.
  - RD_DATA: shift register is loaded from reg[ptr] at entry (HOLD_CYC after the ADDR ACK SCL fall) and re-loaded after each ACK. Drive bits via sda_oe = ~bit; release SDA in the ACK slot. On ACK slot sample: ptr = (ptr+1) mod DEPTH. Controller ACK (SDA=0) keeps RD_DATA; NACK (SDA=1) goes to IGNORE.
  - IGNORE: sda_oe=0; wait for START/STOP.
- Pointer wraps DEPTH-1 -> 0 on both read and write.
- Read data is snapshot at load. Host writes to that register mid-byte do not change the bits in flight.
- Simultaneous host_we and I2C write to the same register in one cycle: the I2C write wins. Different registers: both complete.
- ptr persists across transactions, so a read without a preceding PTR phase starts at the last ptr.
- Exactly 8 wr_pulse cycles for 8 data bytes; none for the pointer byte.

Test Plan:
- Write: S 0xA0 A 0x03 A 0x5A A 0xC3 A P -> reg[3]=0x5A, reg[4]=0xC3, three ACKs plus address ACK, two wr_pulse, busy falls at STOP.
- Combined read: S 0xA0 0x03 Sr 0xA1, read two bytes (ACK then NACK), P -> SDA bytes 0x5A, 0xC3; sda_oe=0 after NACK; ptr=5.
- Address mismatch: S 0xA2 ... P -> sda_oe stays 0 throughout, busy=0, registers unchanged.
- Wrap: write ptr 0x0F, then data 0x11, 0x22 -> reg[15]=0x11, reg[0]=0x22; ptr 0x1F is treated as 0x0F.
- Host collision: host_we to reg[2]=0xFF in the same cycle as I2C write reg[2]=0x77 -> reg[2]=0x77. Host write to reg[6] mid-read-of-reg[6] -> bus still shows the old value.
- Reset mid-read (during bit 3) -> sda_oe=0 immediately, state IDLE, registers 0x00; the next S 0xA1 returns 0x00.
